reservation_station: RTL

Holds decoded ALU, branch and jump instructions until both source operands are available, then issues them to the ALU. It is the receiving end of the decoder's `rs_*` dispatch interface. It snoops the two result buses, ALU and load/store buffer, to wake pending operands, and issues at most one ready entry per cycle.

---
 rtl/reservation_station_pkg.sv | 24 ++
 rtl/reservation_station_if.sv | 50 +++++
 rtl/rs_priority_enc.sv | 23 ++
 rtl/reservation_station.sv | 121 ++++++++++++
 4 files changed

// File: rtl/reservation_station_pkg.sv
// Shared sizing constants and operation encodings for the reservation station,
// the decoder that feeds it and the ALU it issues to.
package reservation_station_pkg;

   localparam int RS_WIDTH   = 3;
   localparam int RS_SIZE    = 1 << RS_WIDTH;
   localparam int ROB_WIDTH  = 4;
   localparam int TYPE_WIDTH = 5;
   localparam int DATA_WIDTH = 32;

   // Operation encodings carried through the station untouched.
   typedef enum logic [TYPE_WIDTH-1:0] {
      RS_TYPE_ADD  = 5'd0,
      RS_TYPE_SUB  = 5'd1,
      RS_TYPE_AND  = 5'd2,
      RS_TYPE_OR   = 5'd3,
      RS_TYPE_XOR  = 5'd4,
      RS_TYPE_BEQ  = 5'd16,
      RS_TYPE_BNE  = 5'd17,
      RS_TYPE_JAL  = 5'd24,
      RS_TYPE_JALR = 5'd25
   } rs_type_e;

endpackage

// File: rtl/reservation_station_if.sv
// Dispatch, result-bus and issue signals of the reservation station.
// master: decoder / result buses / ALU side; slave: the station itself.
interface reservation_station_if #(
   parameter int ROB_WIDTH = reservation_station_pkg::ROB_WIDTH
);
   import reservation_station_pkg::*;

   logic                  rs_rdy;
   logic [TYPE_WIDTH-1:0] rs_type;
   logic [DATA_WIDTH-1:0] rs_data_j;
   logic [DATA_WIDTH-1:0] rs_data_k;
   logic                  rs_pending_j;
   logic                  rs_pending_k;
   logic [ROB_WIDTH-1:0]  rs_dependency_j;
   logic [ROB_WIDTH-1:0]  rs_dependency_k;
   logic [ROB_WIDTH-1:0]  rs_rob_id;
   logic [DATA_WIDTH-1:0] rs_imm;
   logic                  rs_full;

   logic                  alu_cdb_valid;
   logic [ROB_WIDTH-1:0]  alu_cdb_rob_id;
   logic [DATA_WIDTH-1:0] alu_cdb_value;
   logic                  lsb_cdb_valid;
   logic [ROB_WIDTH-1:0]  lsb_cdb_rob_id;
   logic [DATA_WIDTH-1:0] lsb_cdb_value;

   logic                  alu_en;
   logic [TYPE_WIDTH-1:0] alu_type;
   logic [DATA_WIDTH-1:0] alu_op_j;
   logic [DATA_WIDTH-1:0] alu_op_k;
   logic [DATA_WIDTH-1:0] alu_imm;
   logic [ROB_WIDTH-1:0]  alu_rob_id;

   modport master (
      output rs_rdy, rs_type, rs_data_j, rs_data_k, rs_pending_j, rs_pending_k,
             rs_dependency_j, rs_dependency_k, rs_rob_id, rs_imm,
             alu_cdb_valid, alu_cdb_rob_id, alu_cdb_value,
             lsb_cdb_valid, lsb_cdb_rob_id, lsb_cdb_value,
      input  rs_full, alu_en, alu_type, alu_op_j, alu_op_k, alu_imm, alu_rob_id
   );

   modport slave (
      input  rs_rdy, rs_type, rs_data_j, rs_data_k, rs_pending_j, rs_pending_k,
             rs_dependency_j, rs_dependency_k, rs_rob_id, rs_imm,
             alu_cdb_valid, alu_cdb_rob_id, alu_cdb_value,
             lsb_cdb_valid, lsb_cdb_rob_id, lsb_cdb_value,
      output rs_full, alu_en, alu_type, alu_op_j, alu_op_k, alu_imm, alu_rob_id
   );

endinterface

// File: rtl/rs_priority_enc.sv
// Lowest-set-bit encoder: reports whether any request is set and the index
// of the lowest one.
module rs_priority_enc #(
   parameter int WIDTH = 3
) (
   input  logic [(1<<WIDTH)-1:0] req,
   output logic                  found,
   output logic [WIDTH-1:0]      index
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      found = 1'b0;
      index = '0;
      for (int i = (1 << WIDTH) - 1; i >= 0; i--) begin
         if (req[i]) begin
            found = 1'b1;
            index = i[WIDTH-1:0];
         end
      end
   end

endmodule

// File: rtl/reservation_station.sv
// Reservation station: buffers ALU/branch/jump instructions until both
// operands are known, snoops the ALU and load/store result buses for wakeups
// and issues the lowest-index ready entry, at most one per cycle.
module reservation_station #(
   parameter int RS_WIDTH  = reservation_station_pkg::RS_WIDTH,
   parameter int ROB_WIDTH = reservation_station_pkg::ROB_WIDTH
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  rdy_in,
   input  logic                  flush,
   reservation_station_if.slave  rs_bus
);
   import reservation_station_pkg::*;

   localparam int RS_SIZE = 1 << RS_WIDTH;

   logic [RS_SIZE-1:0]    busy;
   logic [RS_SIZE-1:0]    ent_pj;
   logic [RS_SIZE-1:0]    ent_pk;
   logic [TYPE_WIDTH-1:0] ent_type [RS_SIZE];
   logic [DATA_WIDTH-1:0] ent_vj   [RS_SIZE];
   logic [DATA_WIDTH-1:0] ent_vk   [RS_SIZE];
   logic [DATA_WIDTH-1:0] ent_imm  [RS_SIZE];
   logic [ROB_WIDTH-1:0]  ent_qj   [RS_SIZE];
   logic [ROB_WIDTH-1:0]  ent_qk   [RS_SIZE];
   logic [ROB_WIDTH-1:0]  ent_rob  [RS_SIZE];

   logic [RS_SIZE-1:0]    ready;
   logic                  free_found;
   logic                  ready_found;
   logic [RS_WIDTH-1:0]   free_idx;
   logic [RS_WIDTH-1:0]   ready_idx;

   // Readiness looks only at registered flags; a wakeup this cycle shows up next cycle.
   assign ready          = busy & ~ent_pj & ~ent_pk;
   assign rs_bus.rs_full = &busy;

   rs_priority_enc #(.WIDTH(RS_WIDTH)) u_free_enc (
      .req   (~busy),
      .found (free_found),
      .index (free_idx)
   );

   rs_priority_enc #(.WIDTH(RS_WIDTH)) u_ready_enc (
      .req   (ready),
      .found (ready_found),
      .index (ready_idx)
   );

   // True when either result bus broadcasts the given producer id this cycle.
   function automatic logic bus_hit(input logic [ROB_WIDTH-1:0] dep);
      return (rs_bus.alu_cdb_valid && (rs_bus.alu_cdb_rob_id == dep)) ||
             (rs_bus.lsb_cdb_valid && (rs_bus.lsb_cdb_rob_id == dep));
   endfunction

   // Value broadcast for the given id; the ALU bus wins if both match.
   function automatic logic [DATA_WIDTH-1:0] bus_value(input logic [ROB_WIDTH-1:0] dep);
      if (rs_bus.alu_cdb_valid && (rs_bus.alu_cdb_rob_id == dep))
         return rs_bus.alu_cdb_value;
      return rs_bus.lsb_cdb_value;
   endfunction

   // Entry storage, operand wakeup, issue and insert, all gated by rdy_in.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         busy              <= '0;
         rs_bus.alu_en     <= 1'b0;
         rs_bus.alu_type   <= '0;
         rs_bus.alu_op_j   <= '0;
         rs_bus.alu_op_k   <= '0;
         rs_bus.alu_imm    <= '0;
         rs_bus.alu_rob_id <= '0;
      end else if (rdy_in) begin
         if (flush) begin
            busy          <= '0;
            rs_bus.alu_en <= 1'b0;
         end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
               if (busy[i] && ent_pj[i] && bus_hit(ent_qj[i])) begin
                  ent_vj[i] <= bus_value(ent_qj[i]);
                  ent_pj[i] <= 1'b0;
               end
               if (busy[i] && ent_pk[i] && bus_hit(ent_qk[i])) begin
                  ent_vk[i] <= bus_value(ent_qk[i]);
                  ent_pk[i] <= 1'b0;
               end
            end

            if (ready_found) begin
               rs_bus.alu_en     <= 1'b1;
               rs_bus.alu_type   <= ent_type[ready_idx];
               rs_bus.alu_op_j   <= ent_vj[ready_idx];
               rs_bus.alu_op_k   <= ent_vk[ready_idx];
               rs_bus.alu_imm    <= ent_imm[ready_idx];
               rs_bus.alu_rob_id <= ent_rob[ready_idx];
               busy[ready_idx]   <= 1'b0;
            end else begin
               rs_bus.alu_en <= 1'b0;
            end

            // Free slot comes from pre-issue busy bits, so it never collides with the issued slot.
            if (rs_bus.rs_rdy && free_found) begin
               busy[free_idx]     <= 1'b1;
               ent_type[free_idx] <= rs_bus.rs_type;
               ent_imm[free_idx]  <= rs_bus.rs_imm;
               ent_rob[free_idx]  <= rs_bus.rs_rob_id;
               ent_qj[free_idx]   <= rs_bus.rs_dependency_j;
               ent_qk[free_idx]   <= rs_bus.rs_dependency_k;
               ent_pj[free_idx]   <= rs_bus.rs_pending_j && !bus_hit(rs_bus.rs_dependency_j);
               ent_pk[free_idx]   <= rs_bus.rs_pending_k && !bus_hit(rs_bus.rs_dependency_k);
               ent_vj[free_idx]   <= (rs_bus.rs_pending_j && bus_hit(rs_bus.rs_dependency_j)) ?
                                     bus_value(rs_bus.rs_dependency_j) : rs_bus.rs_data_j;
               ent_vk[free_idx]   <= (rs_bus.rs_pending_k && bus_hit(rs_bus.rs_dependency_k)) ?
                                     bus_value(rs_bus.rs_dependency_k) : rs_bus.rs_data_k;
            end
         end
      end
   end

endmodule
